// File: rtl/alu_exec_seq_pkg.sv
// rtl/alu_exec_seq_pkg.sv - shared widths, opcode/funct and ALU code constants, FSM states
package alu_exec_seq_pkg;

  localparam int DATA_W     = 32;
  localparam int OPRN_W     = 6;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [OPRN_W-1:0] ALU_NOP = 6'h00;
  localparam logic [OPRN_W-1:0] ALU_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] ALU_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] ALU_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] ALU_SLL = 6'h04;
  localparam logic [OPRN_W-1:0] ALU_SRL = 6'h05;
  localparam logic [OPRN_W-1:0] ALU_AND = 6'h06;
  localparam logic [OPRN_W-1:0] ALU_OR  = 6'h07;
  localparam logic [OPRN_W-1:0] ALU_NOR = 6'h08;
  localparam logic [OPRN_W-1:0] ALU_SLT = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational opcode/funct decode into ALU operands and writeback info
module alu_exec_decode
  import alu_exec_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int OPRN_WIDTH     = OPRN_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [31:0]               instr,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic [DATA_WIDTH-1:0]     rt_data,
  output logic [OPRN_WIDTH-1:0]     oprn,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [REG_ADDR_WIDTH-1:0] dest,
  output logic                      we,
  output logic                      is_beq,
  output logic                      is_bne,
  output logic                      illegal
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] simm;
  logic [DATA_WIDTH-1:0] zimm;
  logic [DATA_WIDTH-1:0] shamt_ext;
  logic                  unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign simm      = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign zimm      = {{(DATA_WIDTH-16){1'b0}}, instr[15:0]};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, instr[10:6]};
  assign unused_rs = ^instr[25:21];

  always_comb begin
    oprn    = ALU_NOP;
    op1     = rs_data;
    op2     = rt_data;
    dest    = '0;
    we      = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest = instr[15:11];
        we   = 1'b1;
        case (funct)
          FN_ADD:  oprn = ALU_ADD;
          FN_SUB:  oprn = ALU_SUB;
          FN_MUL:  oprn = ALU_MUL;
          FN_AND:  oprn = ALU_AND;
          FN_OR:   oprn = ALU_OR;
          FN_NOR:  oprn = ALU_NOR;
          FN_SLT:  oprn = ALU_SLT;
          FN_SLL: begin oprn = ALU_SLL; op1 = rt_data; op2 = shamt_ext; end
          FN_SRL: begin oprn = ALU_SRL; op1 = rt_data; op2 = shamt_ext; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin oprn = ALU_ADD; op2 = simm; dest = instr[20:16]; we = 1'b1; end
      OP_MULI: begin oprn = ALU_MUL; op2 = simm; dest = instr[20:16]; we = 1'b1; end
      OP_SLTI: begin oprn = ALU_SLT; op2 = simm; dest = instr[20:16]; we = 1'b1; end
      OP_ANDI: begin oprn = ALU_AND; op2 = zimm; dest = instr[20:16]; we = 1'b1; end
      OP_ORI:  begin oprn = ALU_OR;  op2 = zimm; dest = instr[20:16]; we = 1'b1; end
      OP_BEQ:  begin oprn = ALU_SUB; is_beq = 1'b1; end
      OP_BNE:  begin oprn = ALU_SUB; is_bne = 1'b1; end
      default: illegal = 1'b1;
    endcase
    // An illegal instruction still flows through the pipe, but as an inert bubble
    if (illegal) begin
      oprn = ALU_NOP;
      op1  = '0;
      op2  = '0;
      dest = '0;
      we   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage sequencer: accept, drive ALU, capture result, hand to writeback
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int OPRN_WIDTH     = OPRN_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [31:0]               INSTR,
  input  logic [DATA_WIDTH-1:0]     RS_DATA,
  input  logic [DATA_WIDTH-1:0]     RT_DATA,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]     ALU_OUT,
  input  logic                      ALU_ZERO,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_WIDTH-1:0]     RES_DATA,
  output logic [REG_ADDR_WIDTH-1:0] RES_DEST,
  output logic                      RES_WE,
  output logic                      BR_TAKEN,
  output logic                      ILLEGAL
);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     op1_q, op1_d, op2_q, op2_d, res_data_q, res_data_d;
  logic [OPRN_WIDTH-1:0]     oprn_q, oprn_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                      we_q, we_d, ill_q, ill_d, beq_q, beq_d, bne_q, bne_d;
  logic                      br_taken_q, br_taken_d;

  logic [OPRN_WIDTH-1:0]     dec_oprn;
  logic [DATA_WIDTH-1:0]     dec_op1, dec_op2;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic                      dec_we, dec_beq, dec_bne, dec_ill;
  logic                      accept;

  alu_exec_decode #(
    .DATA_WIDTH     (DATA_WIDTH),
    .OPRN_WIDTH     (OPRN_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode (
    .instr   (INSTR),
    .rs_data (RS_DATA),
    .rt_data (RT_DATA),
    .oprn    (dec_oprn),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .dest    (dec_dest),
    .we      (dec_we),
    .is_beq  (dec_beq),
    .is_bne  (dec_bne),
    .illegal (dec_ill)
  );

  assign accept = (state_q == ST_IDLE) && IN_VALID;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      oprn_q     <= '0;
      dest_q     <= '0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      beq_q      <= 1'b0;
      bne_q      <= 1'b0;
      res_data_q <= '0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      oprn_q     <= oprn_d;
      dest_q     <= dest_d;
      we_q       <= we_d;
      ill_q      <= ill_d;
      beq_q      <= beq_d;
      bne_q      <= bne_d;
      res_data_q <= res_data_d;
      br_taken_q <= br_taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (IN_VALID) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (OUT_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/decode registers load only on accept; the ALU result is sampled only in EXEC
  always_comb begin
    op1_d      = op1_q;
    op2_d      = op2_q;
    oprn_d     = oprn_q;
    dest_d     = dest_q;
    we_d       = we_q;
    ill_d      = ill_q;
    beq_d      = beq_q;
    bne_d      = bne_q;
    res_data_d = res_data_q;
    br_taken_d = br_taken_q;
    if (accept) begin
      op1_d  = dec_op1;
      op2_d  = dec_op2;
      oprn_d = dec_oprn;
      dest_d = dec_dest;
      we_d   = dec_we;
      ill_d  = dec_ill;
      beq_d  = dec_beq;
      bne_d  = dec_bne;
    end
    if (state_q == ST_EXEC) begin
      res_data_d = ill_q ? '0 : ALU_OUT;
      br_taken_d = (beq_q & ALU_ZERO) | (bne_q & ~ALU_ZERO);
    end
  end

  always_comb begin
    IN_READY  = RST && (state_q == ST_IDLE);
    OUT_VALID = (state_q == ST_DONE);
    ALU_OP1   = op1_q;
    ALU_OP2   = op2_q;
    ALU_OPRN  = oprn_q;
    RES_DATA  = res_data_q;
    RES_DEST  = dest_q;
    RES_WE    = we_q;
    BR_TAKEN  = br_taken_q;
    ILLEGAL   = ill_q;
  end

endmodule
